// File: rtl/pulse_train_ctrl.sv
// Programmable pulse-train sequencer: NPULSES pulses of ON_TICKS high / OFF_TICKS low,
// where one tick is PRESCALE clocks. Startable from IDLE, abortable while busy.
module pulse_train_ctrl #(
  parameter int PRESCALE = 103,
  parameter int CW       = 4,
  parameter int NW       = 8
) (
  input  logic          i_clk,
  input  logic          i_resetn,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [CW-1:0] i_on_ticks,
  input  logic [CW-1:0] i_off_ticks,
  input  logic [NW-1:0] i_npulses,
  output logic          o_pulse,
  output logic          o_tick,
  output logic          o_busy,
  output logic          o_done,
  output logic [NW-1:0] o_pulse_idx
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_DONE} state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [CW-1:0] r_phase;
  logic [NW-1:0] r_idx;
  logic [CW-1:0] r_sh_on, r_sh_off;
  logic [NW-1:0] r_sh_n;
  logic          r_pulse, r_busy, r_done;

  logic          w_tick;
  logic [CW-1:0] w_on_last, w_off_last;
  logic [NW-1:0] w_idx_last;

  // Zero shadows never reach these compares: they are filtered at START or never enter OFF.
  assign w_tick     = r_busy && (r_presc == P_MAX);
  assign w_on_last  = r_sh_on - CW'(1);
  assign w_off_last = r_sh_off - CW'(1);
  assign w_idx_last = r_sh_n - NW'(1);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_phase  <= '0;
      r_idx    <= '0;
      r_sh_on  <= '0;
      r_sh_off <= '0;
      r_sh_n   <= '0;
      r_pulse  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_presc <= '0;
          if (i_start) begin
            r_sh_on  <= i_on_ticks;
            r_sh_off <= i_off_ticks;
            r_sh_n   <= i_npulses;
            r_phase  <= '0;
            r_idx    <= '0;
            if (i_npulses == '0 || i_on_ticks == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ON;
              r_pulse <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
        end
        S_ON, S_OFF: begin
          if (i_abort) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_phase <= '0;
            r_idx   <= '0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) begin
              if (r_state == S_ON) begin
                if (r_phase == w_on_last) begin
                  r_phase <= '0;
                  if (r_idx == w_idx_last) begin
                    r_state <= S_DONE;
                    r_idx   <= '0;
                    r_presc <= '0;
                    r_pulse <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                  end else if (r_sh_off == '0) begin
                    r_idx <= r_idx + NW'(1);
                  end else begin
                    r_state <= S_OFF;
                    r_pulse <= 1'b0;
                  end
                end else begin
                  r_phase <= r_phase + CW'(1);
                end
              end else begin
                if (r_phase == w_off_last) begin
                  r_phase <= '0;
                  r_idx   <= r_idx + NW'(1);
                  r_state <= S_ON;
                  r_pulse <= 1'b1;
                end else begin
                  r_phase <= r_phase + CW'(1);
                end
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_pulse <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_pulse     = r_pulse;
  assign o_tick      = w_tick;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pulse_idx = r_idx;

endmodule

// File: tb/tb_pulse_train_ctrl.sv
// Directed bench for pulse_train_ctrl with PRESCALE=4; cycle c is the interval after edge c-1,
// sampled on the falling edge.
module tb_pulse_train_ctrl;
  localparam int P  = 4;
  localparam int CW = 4;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] on_t = '0;
  logic [CW-1:0] off_t = '0;
  logic [NW-1:0] npl = '0;
  logic          pulse, tick, busy, done;
  logic [NW-1:0] idx;

  int n_chk = 0;
  int n_err = 0;

  pulse_train_ctrl #(.PRESCALE(P), .CW(CW), .NW(NW)) dut (
    .i_clk(clk), .i_resetn(rst_n), .i_start(start), .i_abort(abort),
    .i_on_ticks(on_t), .i_off_ticks(off_t), .i_npulses(npl),
    .o_pulse(pulse), .o_tick(tick), .o_busy(busy), .o_done(done), .o_pulse_idx(idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // START held across one rising edge (edge 0); returns in cycle 1.
  task automatic go(input int on, input int off, input int n);
    on_t  = CW'(on);
    off_t = CW'(off);
    npl   = NW'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    bit in_a;
    #12;
    chk("rst_pulse", pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tick", tick, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic two-pulse train
    go(2, 3, 2);
    for (int c = 1; c <= 31; c++) begin
      chk($sformatf("t1_pulse@%0d", c), pulse, ((c >= 1 && c <= 8) || (c >= 21 && c <= 28)) ? 1 : 0);
      chk($sformatf("t1_busy@%0d", c), busy, (c >= 1 && c <= 28) ? 1 : 0);
      chk($sformatf("t1_done@%0d", c), done, (c == 29) ? 1 : 0);
      chk($sformatf("t1_tick@%0d", c), tick, (c % 4 == 0 && c <= 28) ? 1 : 0);
      if (c == 1 || c == 12 || c == 20 || c == 21 || c == 28 || c == 29)
        chk($sformatf("t1_idx@%0d", c), idx, (c >= 21 && c <= 28) ? 1 : 0);
      @(negedge clk);
    end

    // 2: degenerate trains complete immediately
    go(2, 3, 0);
    chk("t2n_done1", done, 1);
    chk("t2n_busy1", busy, 0);
    chk("t2n_pulse1", pulse, 0);
    @(negedge clk);
    chk("t2n_done2", done, 0);
    chk("t2n_pulse2", pulse, 0);
    @(negedge clk);
    go(0, 3, 2);
    chk("t2o_done1", done, 1);
    chk("t2o_busy1", busy, 0);
    chk("t2o_pulse1", pulse, 0);
    @(negedge clk);
    chk("t2o_done2", done, 0);
    @(negedge clk);

    // 3: OFF=0 merges pulses
    go(1, 0, 3);
    for (int c = 1; c <= 14; c++) begin
      chk($sformatf("t3_pulse@%0d", c), pulse, (c <= 12) ? 1 : 0);
      chk($sformatf("t3_done@%0d", c), done, (c == 13) ? 1 : 0);
      if (c == 1 || c == 4 || c == 5 || c == 8 || c == 9 || c == 12)
        chk($sformatf("t3_idx@%0d", c), idx, (c - 1) / 4);
      @(negedge clk);
    end

    // 4: abort in OFF, then restart
    go(2, 3, 2);
    for (int c = 1; c <= 16; c++) begin
      abort = (c == 12);
      start = (c == 14);
      if (c <= 12) chk($sformatf("t4_pulse@%0d", c), pulse, (c <= 8) ? 1 : 0);
      else chk($sformatf("t4_pulse@%0d", c), pulse, (c >= 15) ? 1 : 0);
      chk($sformatf("t4_busy@%0d", c), busy, (c <= 12 || c >= 15) ? 1 : 0);
      chk($sformatf("t4_done@%0d", c), done, 0);
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 200 && !done; k++) @(negedge clk);
    chk("t4_done_seen", done, 1);
    @(negedge clk);

    // 5: START held high, config change mid-train
    on_t  = 4'd2;
    off_t = 4'd3;
    npl   = 8'd1;
    start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 12; c++) begin
      if (c == 3) on_t = 4'd5;
      in_a = (c >= 1 && c <= 8) || c >= 11;
      chk($sformatf("t5_pulse@%0d", c), pulse, in_a ? 1 : 0);
      chk($sformatf("t5_busy@%0d", c), busy, in_a ? 1 : 0);
      chk($sformatf("t5_done@%0d", c), done, (c == 9) ? 1 : 0);
      @(negedge clk);
    end
    start = 1'b0;
    for (int c = 13; c <= 30; c++) begin
      chk($sformatf("t5_pulse2@%0d", c), pulse, 1);
      @(negedge clk);
    end
    chk("t5_pulse2@31", pulse, 0);
    chk("t5_done2@31", done, 1);
    @(negedge clk);

    // 6: asynchronous reset mid-ON with TICK high
    go(1, 1, 3);
    for (int c = 1; c < 12; c++) @(negedge clk);
    chk("t6_pre_pulse", pulse, 1);
    chk("t6_pre_tick", tick, 1);
    chk("t6_pre_idx", idx, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_pulse", pulse, 0);
    chk("t6_busy", busy, 0);
    chk("t6_tick", tick, 0);
    chk("t6_done", done, 0);
    chk("t6_idx", idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_post_busy", busy, 0);
    chk("t6_post_idx", idx, 0);
    go(1, 0, 1);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("t6r_pulse@%0d", c), pulse, (c <= 4) ? 1 : 0);
      chk($sformatf("t6r_done@%0d", c), done, (c == 5) ? 1 : 0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1, "timeout");
  end
endmodule
